line_burst_adaptor: RTL

Converts whole-cache-line transfers from the cache's line-wide data arrays into fixed-length bursts on the narrower physical-memory bus, and reassembles read bursts into a full line. Sits directly downstream of the cache data array and controller: on a writeback it consumes the dirty line read out of the data array; on a fill it produces the line that is written back into the array. It implements a single outstanding transaction with a simple request/response handshake on each side.

---
 rtl/line_burst_adaptor.sv | 121 ++++++++++++
 1 files changed

// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor: moves whole cache lines between the cache data array
// and a narrower memory bus. Writebacks are split into BEATS beats and
// fills are reassembled from BEATS beats. One transaction at a time.
//
// Handshake: the cache raises read_i or write_i, and the request is sampled
// only in IDLE. On the memory side, read_o/write_o stay high for the whole
// transfer. Each cycle with resp_i=1 completes one beat: a read beat is taken
// from burst_i, or the write beat on burst_o is consumed. A cycle with
// resp_i=0 is a stall. resp_o pulses for one cycle after the last beat.
module line_burst_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [LINE_WIDTH-1:0] line_i,
    output logic [LINE_WIDTH-1:0] line_o,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic                  read_i,
    input  logic                  write_i,
    output logic                  resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0] address_o,
    output logic                  read_o,
    output logic                  write_o,
    input  logic                  resp_i,
    output logic [1:0]            dbg_state
);

    // LINE_WIDTH must be a power-of-two multiple of BURST_WIDTH.
    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF   = $clog2(LINE_WIDTH / 8);
    localparam logic [KW-1:0]         LAST     = KW'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF) - 64'd1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q;
    logic [LINE_WIDTH-1:0] line_q;   // fill buffer, drives line_o
    logic [LINE_WIDTH-1:0] wline_q;  // writeback line latched at request
    logic [ADDR_WIDTH-1:0] addr_q;

    assign line_o    = line_q;
    assign address_o = addr_q & ~OFF_MASK;
    assign dbg_state = state_q;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state and output decode; outputs depend on registered state only,
    // except the transition itself.
    always_comb begin
        state_d = state_q;
        read_o  = 1'b0;
        write_o = 1'b0;
        resp_o  = 1'b0;
        burst_o = '0;
        case (state_q)
            IDLE: begin
                // A writeback takes priority; a simultaneous fill is dropped.
                if (write_i)     state_d = WRITE;
                else if (read_i) state_d = READ;
            end
            READ: begin
                read_o = 1'b1;
                if (resp_i && k_q == LAST) state_d = DONE;
            end
            WRITE: begin
                write_o = 1'b1;
                burst_o = wline_q[k_q*BURST_WIDTH +: BURST_WIDTH];
                if (resp_i && k_q == LAST) state_d = DONE;
            end
            DONE: begin
                resp_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch the request, count beats, collect fill beats.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_q     <= '0;
            line_q  <= '0;
            wline_q <= '0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (write_i) begin
                        wline_q <= line_i;
                        addr_q  <= address_i;
                        k_q     <= '0;
                    end else if (read_i) begin
                        addr_q  <= address_i;
                        k_q     <= '0;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_q[k_q*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                        k_q <= k_q + KW'(1);
                    end
                end
                WRITE: begin
                    if (resp_i) k_q <= k_q + KW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
